// File: rtl/eigen_power_iter_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eigen_power_iter_ctrl_if : controller <-> eigenrecursion step link         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface eigen_power_iter_ctrl_if #(
  parameter int SIZE_N = 8
);
  logic                     er_rst;
  logic                     er_start;
  logic [SIZE_N-1:0][63:0]  er_vector_in;
  logic [SIZE_N-1:0][63:0]  er_vector_out;
  logic                     er_f;

  modport master (
    output er_rst, er_start, er_vector_in,
    input  er_vector_out, er_f
  );

  modport slave (
    input  er_rst, er_start, er_vector_in,
    output er_vector_out, er_f
  );
endinterface
`default_nettype wire

// File: rtl/eigen_power_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eigen_power_iter_ctrl : power-iteration run controller for eigenrecursion, |
// | ULP-distance convergence test. Optional macro: SIGN_FLIP_EN. Rev 1.0       |
// +----------------------------------------------------------------------------+
module eigen_power_iter_ctrl #(
  parameter int SIZE_N   = 8,
  parameter int MAX_ITER = 64,
  parameter int ULP_TOL  = 1024
) (
  input  wire logic                              clk,
  input  wire logic                              rst_n,
  eigen_power_iter_ctrl_if.master                er,
  input  wire logic                              i_start,
  input  wire logic [SIZE_N-1:0][63:0]           i_vector_init,
  output logic      [SIZE_N-1:0][63:0]           o_vector_out,
  output logic      [$clog2(MAX_ITER+1)-1:0]     o_iterations,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_converged,
`ifdef SIGN_FLIP_EN
  output logic                                   o_converged_neg,
`endif
  output logic                                   o_nan_err
);

  localparam int c_ITW   = $clog2(MAX_ITER+1);
  localparam int c_IDX_W = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REARM   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT_ER = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                   r_state;
  logic [SIZE_N-1:0][63:0]  r_cur;
  logic [SIZE_N-1:0][63:0]  r_nxt;
  logic [SIZE_N-1:0][63:0]  r_vector_out;
  logic [c_ITW-1:0]         r_iter;
  logic [c_IDX_W-1:0]       r_idx;
  logic                     r_all_match;
  logic                     r_any_nan;
  logic                     r_er_rst;
  logic                     r_er_start;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_converged;
  logic                     r_nan_err;

  // Ordered-integer key: monotonic in the represented double value.
  function automatic logic [63:0] f_key(input logic [63:0] x);
    return x[63] ? ~x : (x ^ 64'h8000_0000_0000_0000);
  endfunction

  function automatic logic f_within(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ka;
    logic [63:0] kb;
    logic [63:0] d;
    ka = f_key(a);
    kb = f_key(b);
    d  = (ka >= kb) ? (ka - kb) : (kb - ka);
    return d <= 64'(ULP_TOL);
  endfunction

  logic [63:0] w_nxt_e;
  logic [63:0] w_cur_e;
  logic        w_match;
  logic        w_nan;
  logic        w_all_match;
  logic        w_any_nan;
  logic        w_conv;
  logic        w_last;
  logic        w_budget;

  assign w_nxt_e     = r_nxt[r_idx];
  assign w_cur_e     = r_cur[r_idx];
  assign w_match     = f_within(w_nxt_e, w_cur_e);
  assign w_nan       = &w_nxt_e[62:52];
  assign w_all_match = r_all_match & w_match;
  assign w_any_nan   = r_any_nan | w_nan;
  assign w_last      = (r_idx == c_IDX_W'(SIZE_N-1));
  assign w_budget    = (r_iter == c_ITW'(MAX_ITER));

`ifdef SIGN_FLIP_EN
  logic r_all_match_neg;
  logic r_converged_neg;
  logic w_match_neg;
  logic w_all_match_neg;
  assign w_match_neg     = f_within(w_nxt_e, {~w_cur_e[63], w_cur_e[62:0]});
  assign w_all_match_neg = r_all_match_neg & w_match_neg;
  assign w_conv          = w_all_match | w_all_match_neg;
  assign o_converged_neg = r_converged_neg;
`else
  assign w_conv          = w_all_match;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_nxt        <= '0;
      r_vector_out <= '0;
      r_iter       <= '0;
      r_idx        <= '0;
      r_all_match  <= 1'b0;
      r_any_nan    <= 1'b0;
      r_er_rst     <= 1'b1;
      r_er_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_converged  <= 1'b0;
      r_nan_err    <= 1'b0;
`ifdef SIGN_FLIP_EN
      r_all_match_neg <= 1'b0;
      r_converged_neg <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_er_rst <= i_start;
          if (i_start) begin
            r_cur       <= i_vector_init;
            r_iter      <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_converged <= 1'b0;
            r_nan_err   <= 1'b0;
`ifdef SIGN_FLIP_EN
            r_converged_neg <= 1'b0;
`endif
            r_state     <= S_REARM;
          end
        end
        S_REARM: begin
          r_er_rst   <= 1'b0;
          r_er_start <= 1'b1;
          r_state    <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_ER;
        end
        S_WAIT_ER: begin
          if (er.er_f) begin
            r_nxt       <= er.er_vector_out;
            if (!w_budget) r_iter <= r_iter + c_ITW'(1);
            r_idx       <= '0;
            r_all_match <= 1'b1;
            r_any_nan   <= 1'b0;
`ifdef SIGN_FLIP_EN
            r_all_match_neg <= 1'b1;
`endif
            r_er_start  <= 1'b0;
            r_state     <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_all_match <= w_all_match;
          r_any_nan   <= w_any_nan;
`ifdef SIGN_FLIP_EN
          r_all_match_neg <= w_all_match_neg;
`endif
          r_idx       <= r_idx + c_IDX_W'(1);
          if (w_last) begin
            // Decision cycle: NaN beats convergence beats budget exhaustion.
            if (w_any_nan || w_conv || w_budget) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
              if (w_any_nan) begin
                r_nan_err    <= 1'b1;
                r_vector_out <= r_cur;
              end else begin
                r_converged  <= w_conv;
                r_vector_out <= r_nxt;
`ifdef SIGN_FLIP_EN
                r_converged_neg <= w_conv & ~w_all_match;
`endif
              end
            end else begin
              r_cur    <= r_nxt;
              r_er_rst <= 1'b1;
              r_state  <= S_REARM;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign er.er_rst       = r_er_rst;
  assign er.er_start     = r_er_start;
  assign er.er_vector_in = r_cur;
  assign o_vector_out    = r_vector_out;
  assign o_iterations    = r_iter;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_converged     = r_converged;
  assign o_nan_err       = r_nan_err;

endmodule
`default_nettype wire

// File: tb/tb_eigen_power_iter_ctrl.sv
`default_nettype none
// Self-checking bench for eigen_power_iter_ctrl with a behavioural eigenrecursion model.
module tb_eigen_power_iter_ctrl;
  localparam int N   = 8;
  localparam int MI  = 4;
  localparam int TOL = 1024;
  localparam logic [63:0] SGN = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                start;
  logic [N-1:0][63:0]  vinit;
  logic [N-1:0][63:0]  vout;
  logic [2:0]          iters;
  logic                busy, done, conv, nan_err;
`ifdef SIGN_FLIP_EN
  logic                conv_neg;
`endif

  eigen_power_iter_ctrl_if #(.SIZE_N(N)) er_if ();

  eigen_power_iter_ctrl #(.SIZE_N(N), .MAX_ITER(MI), .ULP_TOL(TOL)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .er            (er_if),
    .i_start       (start),
    .i_vector_init (vinit),
    .o_vector_out  (vout),
    .o_iterations  (iters),
    .o_busy        (busy),
    .o_done        (done),
    .o_converged   (conv),
`ifdef SIGN_FLIP_EN
    .o_converged_neg (conv_neg),
`endif
    .o_nan_err     (nan_err)
  );

  // Behavioural eigenrecursion: answers 3 cycles into a step, sticky er_f until er_rst.
  logic [2:0]  m_mode;
  logic [63:0] m_base;
  logic [63:0] m_vd;
  logic        m_clr;
  int          m_step;
  int          m_lat;

  function automatic logic [N-1:0][63:0] f_model(input int s, input logic [N-1:0][63:0] vin);
    logic [N-1:0][63:0] r;
    for (int i = 0; i < N; i++) r[i] = m_base;
    case (m_mode)
      3'd1: if (s % 2 == 1) for (int i = 0; i < N; i++) r[i] = m_vd;
      3'd2: r[3] = m_base + 64'd1024;
      3'd3: r[3] = m_base + 64'd1025;
      3'd4: begin
        for (int i = 0; i < N; i++) r[i] = m_vd;
        if (s >= 2) r[5] = 64'h7FF8_0000_0000_0000;
      end
      3'd5: for (int i = 0; i < N; i++) r[i] = vin[i] ^ SGN;
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (er_if.er_rst) begin
      er_if.er_f <= 1'b0;
      m_lat      <= 0;
    end else if (er_if.er_start && !er_if.er_f) begin
      if (m_lat == 2) begin
        er_if.er_f          <= 1'b1;
        er_if.er_vector_out <= f_model(m_step + 1, er_if.er_vector_in);
        m_step              <= m_step + 1;
      end else begin
        m_lat <= m_lat + 1;
      end
    end
    if (m_clr) m_step <= 0;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  task automatic launch(input logic [2:0] mode, input logic [63:0] base);
    @(negedge clk);
    m_mode = mode;
    m_base = base;
    m_clr  = 1'b1;
    for (int i = 0; i < N; i++) vinit[i] = base;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    m_clr  = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [63:0] base;
    int          exp_it;
    logic        exp_conv;
    logic        exp_nan;
    logic        exp_neg;
    logic [63:0] e0, e3, e5;
  } vec_t;

  vec_t tbl[8];

  logic [63:0] v, nv;

  initial begin
    start  = 1'b0;
    vinit  = '0;
    m_mode = 3'd0;
    m_base = '0;
    m_clr  = 1'b1;
    v      = $realtobits(0.3535533906);
    nv     = v ^ SGN;
    m_vd   = $realtobits(0.3535533906 + 1.0e-3);

    tbl[0] = '{3'd0, v,  1, 1'b1, 1'b0, 1'b0, v,    v,              v};
    tbl[1] = '{3'd0, nv, 1, 1'b1, 1'b0, 1'b0, nv,   nv,             nv};
    tbl[2] = '{3'd1, v,  4, 1'b0, 1'b0, 1'b0, v,    v,              v};
    tbl[3] = '{3'd2, v,  1, 1'b1, 1'b0, 1'b0, v,    v + 64'd1024,   v};
    tbl[4] = '{3'd3, v,  2, 1'b1, 1'b0, 1'b0, v,    v + 64'd1025,   v};
    tbl[5] = '{3'd2, nv, 1, 1'b1, 1'b0, 1'b0, nv,   nv + 64'd1024,  nv};
    tbl[6] = '{3'd4, v,  2, 1'b0, 1'b1, 1'b0, m_vd, m_vd,           m_vd};
`ifdef SIGN_FLIP_EN
    tbl[7] = '{3'd5, v,  1, 1'b1, 1'b0, 1'b1, nv,   nv,             nv};
`else
    tbl[7] = '{3'd5, v,  4, 1'b0, 1'b0, 1'b0, v,    v,              v};
`endif

    // Reset state while rst_n is held low.
    repeat (3) @(negedge clk);
    chk("rst_er_rst",   64'(er_if.er_rst),   64'd1);
    chk("rst_er_start", 64'(er_if.er_start), 64'd0);
    chk("rst_busy",     64'(busy),           64'd0);
    chk("rst_done",     64'(done),           64'd0);
    chk("rst_iters",    64'(iters),          64'd0);
    chk("rst_vout0",    vout[0],             64'd0);
    chk("rst_er_vin0",  er_if.er_vector_in[0], 64'd0);
    rst_n = 1'b1;
    m_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_er_rst",   64'(er_if.er_rst),   64'd0);
    chk("idle_er_start", 64'(er_if.er_start), 64'd0);

    for (int t = 0; t < 8; t++) begin
      launch(tbl[t].mode, tbl[t].base);
      wait_done();
      chk($sformatf("v%0d_busy", t),  64'(busy),    64'd0);
      chk($sformatf("v%0d_iters", t), 64'(iters),   64'(tbl[t].exp_it));
      chk($sformatf("v%0d_conv", t),  64'(conv),    64'(tbl[t].exp_conv));
      chk($sformatf("v%0d_nan", t),   64'(nan_err), 64'(tbl[t].exp_nan));
`ifdef SIGN_FLIP_EN
      chk($sformatf("v%0d_neg", t),   64'(conv_neg), 64'(tbl[t].exp_neg));
`endif
      chk($sformatf("v%0d_out0", t),  vout[0], tbl[t].e0);
      chk($sformatf("v%0d_out3", t),  vout[3], tbl[t].e3);
      chk($sformatf("v%0d_out5", t),  vout[5], tbl[t].e5);
    end

    // One-cycle rearm pulse then launch; start while busy is ignored.
    @(negedge clk);
    m_mode = 3'd0;
    m_base = v;
    m_clr  = 1'b1;
    for (int i = 0; i < N; i++) vinit[i] = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    m_clr  = 1'b0;
    chk("rearm_er_rst",   64'(er_if.er_rst),   64'd1);
    chk("rearm_er_start", 64'(er_if.er_start), 64'd0);
    chk("rearm_busy",     64'(busy),           64'd1);
    chk("rearm_done",     64'(done),           64'd0);
    @(negedge clk);
    chk("launch_er_rst",   64'(er_if.er_rst),   64'd0);
    chk("launch_er_start", 64'(er_if.er_start), 64'd1);
    for (int i = 0; i < N; i++) vinit[i] = nv;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("busy_ign_out0",  vout[0],       v);
    chk("busy_ign_iters", 64'(iters),    64'd1);
    chk("busy_ign_conv",  64'(conv),     64'd1);

    // Asynchronous reset in the middle of the second step.
    launch(3'd1, v);
    begin
      int cyc = 0;
      while (!(iters == 3'd2 && er_if.er_start) && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      chk("reach_step2", 64'(iters == 3'd2 && er_if.er_start), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   64'(busy),          64'd0);
    chk("arst_done",   64'(done),          64'd0);
    chk("arst_iters",  64'(iters),         64'd0);
    chk("arst_er_rst", 64'(er_if.er_rst),  64'd1);
    chk("arst_er_start", 64'(er_if.er_start), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_er_rst",   64'(er_if.er_rst),   64'd0);
    chk("rel_er_start", 64'(er_if.er_start), 64'd0);
    chk("rel_busy",     64'(busy),           64'd0);

    launch(3'd0, nv);
    wait_done();
    chk("post_rst_conv", 64'(conv), 64'd1);
    chk("post_rst_out7", vout[7],   nv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
